// File: rtl/pwm_pkg.sv
// pwm_pkg: shared width, dead-time counter width and the duty value type used
// by the PWM compare block and its dead-band sub-module.
package pwm_pkg;

   // Default width of the count and duty buses (matches the upstream counter).
   localparam int PWM_W_DEFAULT = 8;

   // Width of the dead-time down-counter; holds DEAD values 1..15.
   localparam int DEAD_CNT_W = 4;

   typedef logic [PWM_W_DEFAULT-1:0] duty_t;

endpackage

// File: rtl/pwm_deadband.sv
// pwm_deadband: turns the raw compare result into a pair of non-overlapping
// complementary outputs. Every edge of r reloads a down-counter with DEAD,
// and both outputs are held low while it is nonzero. A phase of r shorter
// than DEAD cycles never reaches its output.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset (counter cleared, outputs low)
//   r    in   raw compare result (count < eff), combinational
//   p    out  true output, registered
//   n    out  complementary output, registered
module pwm_deadband
   import pwm_pkg::*;
#(
   parameter int DEAD = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic r,
   output logic p,
   output logic n
);

   logic                  r_prev_q, r_prev_d;
   logic [DEAD_CNT_W-1:0] cnt_q, cnt_d;
   logic                  p_q, p_d;
   logic                  n_q, n_d;

   always_comb begin
      r_prev_d = r;
      cnt_d    = cnt_q;
      if (r != r_prev_q) begin
         cnt_d = DEAD_CNT_W'(DEAD);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - DEAD_CNT_W'(1);
      end
      // Outputs follow the counter value being loaded this cycle, so an edge
      // blanks both outputs starting on the very next registered sample.
      p_d = r & (cnt_d == '0);
      n_d = ~r & (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_q <= 1'b0;
         cnt_q    <= '0;
         p_q      <= 1'b0;
         n_q      <= 1'b0;
      end else begin
         r_prev_q <= r_prev_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         n_q      <= n_d;
      end
   end

   assign p = p_q;
   assign n = n_q;

endmodule

// File: rtl/pwm_compare.sv
// pwm_compare: converts a free-running count into a PWM waveform with a
// double-buffered duty. A valid/ready write loads a shadow register; the
// shadow becomes the active duty only at the next period boundary (count
// returning to 0, either by wrap or by an upstream counter reset).
//
// Optional feature macro: PWM_COMPLEMENTARY_EN adds the pwm_n port and a
// dead-time stage (pwm_deadband) in front of both outputs.
//
// Ports:
//   clk           in   rising-edge clock shared with the counter
//   rst           in   synchronous active-high reset
//   count         in   count from the upstream counter
//   duty_valid    in   duty write request (hold until accepted)
//   duty_in       in   requested duty
//   duty_ready    out  no update pending; a write is accepted this cycle
//   duty_active   out  duty currently in force
//   pwm_out       out  PWM output, 1-cycle latency from count
//   period_start  out  one-cycle pulse on a period boundary
//   match         out  one-cycle pulse when count equals the compare value
//   pwm_n         out  complementary output (PWM_COMPLEMENTARY_EN only)
module pwm_compare
   import pwm_pkg::*;
#(
   parameter int             W        = PWM_W_DEFAULT,
   parameter logic [W-1:0]   DUTY_RST = '0,
   parameter int             DEAD     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] count,
   input  logic         duty_valid,
   input  logic [W-1:0] duty_in,
   output logic         duty_ready,
   output logic [W-1:0] duty_active,
   output logic         pwm_out,
`ifdef PWM_COMPLEMENTARY_EN
   output logic         pwm_n,
`endif
   output logic         period_start,
   output logic         match
);

   logic [W-1:0] count_q, count_d;
   logic         first_q, first_d;
   logic [W-1:0] shadow_q, shadow_d;
   logic         pending_q, pending_d;
   logic [W-1:0] duty_active_q, duty_active_d;
   logic         period_start_q, period_start_d;
   logic         match_q, match_d;

   logic         boundary;
   logic         accept;
   logic         apply;
   logic [W-1:0] eff;
   logic         raw;

   always_comb begin
      // A held count of 0 gives a single boundary; first covers count==0
      // straight out of reset when count_q carries no history.
      boundary = (count == '0) && ((count_q != '0) || first_q);
      accept   = duty_valid && !pending_q;
      apply    = boundary && pending_q;
      // The newly applied duty already governs the count==0 sample.
      eff      = apply ? shadow_q : duty_active_q;
      raw      = (count < eff);

      count_d       = count;
      first_d       = 1'b0;
      shadow_d      = shadow_q;
      pending_d     = pending_q;
      duty_active_d = duty_active_q;

      // accept needs pending=0 and apply needs pending=1, so a write landing
      // on a boundary waits in the shadow for the following boundary.
      if (accept) begin
         shadow_d  = duty_in;
         pending_d = 1'b1;
      end
      if (apply) begin
         duty_active_d = shadow_q;
         pending_d     = 1'b0;
      end

      period_start_d = boundary;
      match_d        = (count == eff);
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
      if (rst) begin
         first_q        <= 1'b1;
         shadow_q       <= '0;
         pending_q      <= 1'b0;
         duty_active_q  <= DUTY_RST;
         period_start_q <= 1'b0;
         match_q        <= 1'b0;
      end else begin
         first_q        <= first_d;
         shadow_q       <= shadow_d;
         pending_q      <= pending_d;
         duty_active_q  <= duty_active_d;
         period_start_q <= period_start_d;
         match_q        <= match_d;
      end
   end

   assign duty_ready   = !pending_q;
   assign duty_active  = duty_active_q;
   assign period_start = period_start_q;
   assign match        = match_q;

`ifdef PWM_COMPLEMENTARY_EN
   pwm_deadband #(
      .DEAD (DEAD)
   ) u_deadband (
      .clk (clk),
      .rst (rst),
      .r   (raw),
      .p   (pwm_out),
      .n   (pwm_n)
   );
`else
   logic pwm_q, pwm_d;

   // DEAD only shapes the complementary outputs.
   logic unused_dead;
   assign unused_dead = ^DEAD_CNT_W'(DEAD);

   always_comb begin
      pwm_d = raw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;
`endif

endmodule
